// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the parallel-ADC sampler.
// The ADC_SAMPLER_AVG_EN build macro is described in adc_sampler.sv.
package adc_sampler_pkg;

    localparam int ADC_W          = 8;
    localparam int DEF_SAMPLE_DIV = 500;
    localparam int DEF_WR_PULSE   = 4;
    localparam int DEF_RD_PULSE   = 4;
    localparam int DEF_TIMEOUT    = 255;
    localparam int AVG_DEPTH      = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_CONVERT = 2'd2,
        S_READ    = 2'd3
    } adc_state_e;

    typedef logic [AVG_DEPTH-1:0][ADC_W-1:0] adc_hist_t;

    // Mean of the history; the two extra sum bits cover four full-scale bytes.
    function automatic logic [ADC_W-1:0] adc_avg4(input adc_hist_t h);
        logic [ADC_W+1:0] sum;
        sum = '0;
        for (int i = 0; i < AVG_DEPTH; i++) begin
            sum = sum + {2'b00, h[i]};
        end
        return sum[ADC_W+1:2];
    endfunction

endpackage

// File: rtl/adc_sampler_tick_divider.sv
// Conversion pacing divider: one-cycle tick every SAMPLE_DIV cycles
// while enabled, counter held at zero otherwise.
module sample_tick_divider
    import adc_sampler_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/adc_sampler.sv
// Parallel ADC handshake (start / wait INTR_n / read) with ready and error flags.
// Build macro ADC_SAMPLER_AVG_EN: sample is the mean of the last four conversions.
module adc_sampler
    import adc_sampler_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int WR_PULSE   = DEF_WR_PULSE,
    parameter int RD_PULSE   = DEF_RD_PULSE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             enable,
    input  logic             sample_ack,
    input  logic             adc_intr_n,
    input  logic [ADC_W-1:0] adc_data,
    output logic             adc_cs_n,
    output logic             adc_wr_n,
    output logic             adc_rd_n,
    output logic [ADC_W-1:0] sample,
    output logic             sample_ready,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int CNT_M1  = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
    localparam int CNT_MAX = (CNT_M1 > TIMEOUT) ? CNT_M1 : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             tick;
    logic [1:0]       sync_q;
    logic             intr_s_n;
    adc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cs_n_q;
    logic             wr_n_q;
    logic             rd_n_q;
    logic             done_q;
    logic             terr_q;
    logic             latch_w;
    logic [ADC_W-1:0] sample_q;
    logic             ready_q;
    logic             ready_d;
    logic             ovr_q;
    logic             ovr_d;
`ifdef ADC_SAMPLER_AVG_EN
    adc_hist_t        hist_q;
`endif

    sample_tick_divider #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_div (
        .clock     (clock),
        .ctrl_reset(ctrl_reset),
        .enable    (enable),
        .tick      (tick)
    );

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], adc_intr_n};
        end
    end

    assign intr_s_n = sync_q[1];
    assign latch_w  = (state_q == S_READ) && (cnt_q == RD_LAST);

    // done_q marks the cycle after the latch edge; ready/average update there.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (done_q) begin
                terr_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        wr_n_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == WR_LAST) begin
                        state_q <= S_CONVERT;
                        cnt_q   <= '0;
                        wr_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (!intr_s_n) begin
                        state_q <= S_READ;
                        cnt_q   <= '0;
                        rd_n_q  <= 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_IDLE;
                        cs_n_q  <= 1'b1;
                        terr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (latch_w) begin
                        state_q <= S_IDLE;
                        cs_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_d = ready_q;
        if (done_q) begin
            ready_d = 1'b1;
        end else if (sample_ack) begin
            ready_d = 1'b0;
        end
        ovr_d = ovr_q | (done_q & ready_q);
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            sample_q <= '0;
`ifdef ADC_SAMPLER_AVG_EN
            hist_q   <= '0;
`endif
        end else begin
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
`ifdef ADC_SAMPLER_AVG_EN
            if (latch_w) begin
                hist_q <= {hist_q[AVG_DEPTH-2:0], adc_data};
            end
            if (done_q) begin
                sample_q <= adc_avg4(hist_q);
            end
`else
            if (latch_w) begin
                sample_q <= adc_data;
            end
`endif
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_wr_n     = wr_n_q;
    assign adc_rd_n     = rd_n_q;
    assign sample       = sample_q;
    assign sample_ready = ready_q;
    assign overrun      = ovr_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Self-checking bench for adc_sampler with a behavioural ADC and result model.
// Works for both the raw and the ADC_SAMPLER_AVG_EN builds.
module tb_adc_sampler;

    localparam int SDIV  = 20;
    localparam int WRP   = 2;
    localparam int RDP   = 3;
    localparam int TOUT  = 10;
    localparam int DWELL = 8;

    typedef struct {
        logic [7:0] data;
        bit         resp;
        bit         ack_b;
        bit         ack_c;
        logic [7:0] exp_sample;
        bit         exp_ready;
        bit         exp_tout;
        bit         exp_ovr;
    } vec_t;

    logic       clock = 1'b0;
    logic       ctrl_reset;
    logic       enable;
    logic       sample_ack;
    logic       adc_intr_n = 1'b1;
    logic [7:0] adc_data;
    logic       adc_cs_n;
    logic       adc_wr_n;
    logic       adc_rd_n;
    logic [7:0] sample;
    logic       sample_ready;
    logic       overrun;
    logic       timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    bit intr_resp = 1'b1;
    bit wr_prev   = 1'b1;
    int intr_cnt  = 0;

    bit         m_ready;
    bit         m_ovr;
    bit         m_tout;
    logic [7:0] m_sample;
    int         hist[4];

    vec_t       tbl[5];
    logic [7:0] avg_in[4];
    logic [7:0] avg_exp[4];
    int         wr_c;
    int         rd_c;
    int         cv_c;
    int         guard;
    int         wr_seen;
    logic [7:0] exp_s;

    always #5 clock = ~clock;

    adc_sampler #(
        .SAMPLE_DIV(SDIV),
        .WR_PULSE  (WRP),
        .RD_PULSE  (RDP),
        .TIMEOUT   (TOUT)
    ) dut (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .enable      (enable),
        .sample_ack  (sample_ack),
        .adc_intr_n  (adc_intr_n),
        .adc_data    (adc_data),
        .adc_cs_n    (adc_cs_n),
        .adc_wr_n    (adc_wr_n),
        .adc_rd_n    (adc_rd_n),
        .sample      (sample),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    // ADC: INTR_n falls 5 cycles after WR_n rises, released when RD_n is low.
    always @(negedge clock) begin
        if (ctrl_reset) begin
            adc_intr_n = 1'b1;
            intr_cnt   = 0;
            wr_prev    = 1'b1;
        end else begin
            if (!adc_rd_n) adc_intr_n = 1'b1;
            if (adc_wr_n && !wr_prev && intr_resp) begin
                intr_cnt = 5;
            end else if (intr_cnt > 0) begin
                intr_cnt--;
                if (intr_cnt == 0) adc_intr_n = 1'b0;
            end
            wr_prev = adc_wr_n;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ready  = 1'b0;
        m_ovr    = 1'b0;
        m_tout   = 1'b0;
        m_sample = 8'h00;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    task automatic model_conv(input logic [7:0] d, input bit resp);
        if (resp) begin
            m_ovr   = m_ovr | m_ready;
            m_ready = 1'b1;
            m_tout  = 1'b0;
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(d);
`ifdef ADC_SAMPLER_AVG_EN
            m_sample = 8'((hist[0] + hist[1] + hist[2] + hist[3]) / 4);
`else
            m_sample = d;
`endif
        end else begin
            m_tout = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sample"}, 32'(sample), 32'(m_sample));
        chk({tag, ".ready"}, 32'(sample_ready), 32'(m_ready));
        chk({tag, ".tout"}, 32'(timeout_err), 32'(m_tout));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic run_conv(input logic [7:0] d, input bit resp,
                            input bit ack_b, input bit ack_c,
                            output int o_wr, output int o_rd, output int o_cv);
        int g;
        o_wr      = 0;
        o_rd      = 0;
        o_cv      = 0;
        adc_data  = d;
        intr_resp = resp;
        if (ack_b) begin
            @(negedge clock);
            sample_ack = 1'b1;
            @(negedge clock);
            sample_ack = 1'b0;
            m_ready = 1'b0;
            chk("ack_clears_ready", 32'(sample_ready), 32'(0));
        end
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (adc_cs_n && g < 3 * SDIV);
        if (adc_cs_n) begin
            chk("start_wait", 32'(adc_cs_n), 32'(0));
            return;
        end
        g = 0;
        while (!adc_cs_n && g < 4 * SDIV) begin
            if (!adc_wr_n) o_wr++;
            else if (!adc_rd_n) o_rd++;
            else o_cv++;
            @(negedge clock);
            g++;
        end
        chk("cs_release", 32'(adc_cs_n), 32'(1));
        chk("ready_not_early", 32'(sample_ready), 32'(m_ready));
        if (ack_c) sample_ack = 1'b1;
        @(negedge clock);
        sample_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h10, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h20, 1'b1, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h77, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{8'h33, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
        avg_in = '{8'd8, 8'd16, 8'd24, 8'd32};
`ifdef ADC_SAMPLER_AVG_EN
        avg_exp = '{8'd2, 8'd6, 8'd12, 8'd20};
`else
        avg_exp = '{8'd8, 8'd16, 8'd24, 8'd32};
`endif

        ctrl_reset = 1'b1;
        enable     = 1'b0;
        sample_ack = 1'b0;
        adc_data   = 8'h00;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst.cs_n", 32'(adc_cs_n), 32'(1));
        chk("rst.wr_n", 32'(adc_wr_n), 32'(1));
        chk("rst.rd_n", 32'(adc_rd_n), 32'(1));
        chk("rst.sample", 32'(sample), 32'(0));
        chk("rst.ready", 32'(sample_ready), 32'(0));
        chk("rst.ovr", 32'(overrun), 32'(0));
        chk("rst.tout", 32'(timeout_err), 32'(0));
        ctrl_reset = 1'b0;
        enable     = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_conv(tbl[i].data, tbl[i].resp, tbl[i].ack_b, tbl[i].ack_c,
                     wr_c, rd_c, cv_c);
            model_conv(tbl[i].data, tbl[i].resp);
            chk($sformatf("v%0d.wr_pulse", i), wr_c, WRP);
            if (tbl[i].resp) begin
                chk($sformatf("v%0d.rd_pulse", i), rd_c, RDP);
                chk($sformatf("v%0d.dwell", i), cv_c, DWELL);
            end else begin
                chk($sformatf("v%0d.rd_pulse", i), rd_c, 0);
                chk($sformatf("v%0d.dwell", i), cv_c, TOUT);
            end
`ifdef ADC_SAMPLER_AVG_EN
            exp_s = m_sample;
`else
            exp_s = tbl[i].exp_sample;
`endif
            chk($sformatf("v%0d.sample", i), 32'(sample), 32'(exp_s));
            chk($sformatf("v%0d.ready", i), 32'(sample_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("v%0d.tout", i), 32'(timeout_err), 32'(tbl[i].exp_tout));
            chk($sformatf("v%0d.ovr", i), 32'(overrun), 32'(tbl[i].exp_ovr));
        end

        adc_data  = 8'h5A;
        intr_resp = 1'b1;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (adc_rd_n && guard < 3 * SDIV);
        chk("rstread.reached_read", 32'(adc_rd_n), 32'(0));
        #2 ctrl_reset = 1'b1;
        #1;
        chk("rstread.rd_n", 32'(adc_rd_n), 32'(1));
        chk("rstread.cs_n", 32'(adc_cs_n), 32'(1));
        chk("rstread.ready", 32'(sample_ready), 32'(0));
        chk("rstread.ovr", 32'(overrun), 32'(0));
        chk("rstread.sample", 32'(sample), 32'(0));
        model_reset();
        @(negedge clock);
        ctrl_reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_conv(avg_in[i], 1'b1, 1'b1, 1'b0, wr_c, rd_c, cv_c);
            model_conv(avg_in[i], 1'b1);
            chk($sformatf("avg%0d.sample", i), 32'(sample), 32'(avg_exp[i]));
            chk($sformatf("avg%0d.ready", i), 32'(sample_ready), 32'(1));
        end

        @(negedge clock);
        sample_ack = 1'b1;
        @(negedge clock);
        sample_ack = 1'b0;
        m_ready   = 1'b0;
        adc_data  = 8'h3C;
        intr_resp = 1'b1;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(!adc_cs_n && adc_wr_n && adc_rd_n) && guard < 3 * SDIV);
        enable = 1'b0;
        guard = 0;
        while (!sample_ready && guard < 4 * SDIV) begin
            @(negedge clock);
            guard++;
        end
        model_conv(8'h3C, 1'b1);
        chk("endrop.final_ready", 32'(sample_ready), 32'(1));
        chk("endrop.sample", 32'(sample), 32'(m_sample));
        wr_seen = 0;
        repeat (3 * SDIV) begin
            @(negedge clock);
            if (!adc_wr_n) wr_seen++;
        end
        chk("endrop.no_restart", wr_seen, 0);

        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            bit r, ab, ac;
            d  = 8'($urandom_range(0, 255));
            r  = ($urandom_range(0, 5) != 0);
            ab = 1'($urandom_range(0, 1));
            ac = r && ($urandom_range(0, 3) == 0);
            run_conv(d, r, ab, ac, wr_c, rd_c, cv_c);
            model_conv(d, r);
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
